// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: parity modes, transmitter/receiver FSM states,
// baud divisor and parity helpers.
package rs232_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_e;

  // Rounded clock cycles per bit.
  function automatic int baud_count(input real clock_freq, input real baud_rate);
    return $rtoi(clock_freq / baud_rate + 0.5);
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input int data_bits,
                                      input logic [1:0] mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < data_bits) begin
        x = x ^ data[i];
      end
    end
    return (mode == PARITY_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/rs232_baud_gen.sv
// Load/enable down-counter giving a one-cycle tick every BAUD_COUNT cycles;
// the count is held while disabled.
module rs232_baud_gen #(
  parameter int BAUD_COUNT = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic tick
);

  localparam int CW = (BAUD_COUNT < 2) ? 1 : $clog2(BAUD_COUNT);
  localparam logic [CW-1:0] RELOAD = CW'(BAUD_COUNT - 1);

  logic [CW-1:0] cnt_r;

  // Bit-period down-counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= RELOAD;
    end else if (load) begin
      cnt_r <= RELOAD;
    end else if (enable) begin
      if (cnt_r == '0) begin
        cnt_r <= RELOAD;
      end else begin
        cnt_r <= cnt_r - CW'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = enable && (cnt_r == '0);

endmodule

// File: rtl/axis_rs232_tx.sv
// AXI-stream to RS232 transmitter with inline FIFO.
// Define AXIS_RS232_TX_CTS_EN to gate frame starts on the synchronised ctsn_pin.
module axis_rs232_tx
  import rs232_pkg::*;
#(
  parameter real CLOCK_FREQ = 133000000.0,
  parameter real BAUD_RATE  = 115200.0,
  parameter int  DATA_BITS  = 8,
  parameter int  PARITY     = 0,
  parameter int  STOP_BITS  = 1,
  parameter int  FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] idata,
  input  logic       ivalid,
  output logic       iready,
  output logic       txd_pin,
  input  logic       ctsn_pin,
  output logic       busy
);

  localparam int BAUD_COUNT = baud_count(CLOCK_FREQ, BAUD_RATE);
  localparam int AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [1:0] PAR_MODE = 2'(PARITY);
  localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DATA_BITS);

  if (BAUD_COUNT < 2) begin : g_bad_baud
    $error("axis_rs232_tx: BAUD_COUNT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("axis_rs232_tx: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("axis_rs232_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("axis_rs232_tx: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axis_rs232_tx: FIFO_DEPTH must be a power of two, at least 2");
  end

  logic [7:0]  mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0] count_r, count_s;
  logic        iready_r, push_s, pop_s, empty_s;

  tx_state_e   state_r, state_s;
  logic        start_s, tick_s, cts_s, txd_s;
  logic [7:0]  head_s, shift_r;
  logic        par_r, txd_r, busy_r;
  logic [2:0]  bit_cnt_r;

  assign push_s  = ivalid && iready_r;
  assign pop_s   = start_s;
  assign empty_s = (count_r == '0);
  assign head_s  = mem_r[rd_ptr_r] & DATA_MASK;

`ifdef AXIS_RS232_TX_CTS_EN
  logic [1:0] ctsn_sync_r;

  // Two-flop synchroniser for the asynchronous clear-to-send pin.
  always_ff @(posedge clock) begin
    if (reset) begin
      ctsn_sync_r <= 2'b11;
    end else begin
      ctsn_sync_r <= {ctsn_sync_r[0], ctsn_pin};
    end
  end

  assign cts_s = ~ctsn_sync_r[1];
`else
  logic ctsn_unused_s;
  assign ctsn_unused_s = ctsn_pin;
  assign cts_s = 1'b1;
`endif

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + (AW+1)'(1'b1);
      2'b01:   count_s = count_r - (AW+1)'(1'b1);
      default: count_s = count_r;
    endcase
  end

  // FIFO storage.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= idata;
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      iready_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r  <= count_s;
      iready_r <= (count_s != FULL_COUNT);
    end
  end

  rs232_baud_gen #(.BAUD_COUNT(BAUD_COUNT)) u_baud (
    .clock  (clock),
    .reset  (reset),
    .load   (start_s),
    .enable (state_r != IDLE),
    .tick   (tick_s)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state; leaving STOP may start the next frame directly.
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s && cts_s) begin
          state_s = START;
          start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (tick_s) state_s = DATA;
        else        state_s = START;
      end
      DATA: begin
        if (tick_s && bit_cnt_r == LAST_DATA) begin
          state_s = (PAR_MODE != PARITY_NONE) ? PAR : STOP;
        end else begin
          state_s = DATA;
        end
      end
      PAR: begin
        if (tick_s) state_s = STOP;
        else        state_s = PAR;
      end
      STOP: begin
        if (tick_s && bit_cnt_r == LAST_STOP) begin
          if (!empty_s && cts_s) begin
            state_s = START;
            start_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Frame datapath: byte/parity latch on start, shift and bit counting on ticks.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_r   <= 8'd0;
      par_r     <= 1'b0;
      bit_cnt_r <= 3'd0;
    end else if (start_s) begin
      shift_r   <= head_s;
      par_r     <= parity_bit(head_s, DATA_BITS, PAR_MODE);
      bit_cnt_r <= 3'd0;
    end else if (tick_s) begin
      case (state_r)
        DATA: begin
          shift_r   <= {1'b0, shift_r[7:1]};
          bit_cnt_r <= (bit_cnt_r == LAST_DATA) ? 3'd0 : bit_cnt_r + 3'd1;
        end
        STOP:    bit_cnt_r <= bit_cnt_r + 3'd1;
        default: bit_cnt_r <= bit_cnt_r;
      endcase
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Line level for the current state.
  always_comb begin
    txd_s = 1'b1;
    case (state_r)
      IDLE:    txd_s = 1'b1;
      START:   txd_s = 1'b0;
      DATA:    txd_s = shift_r[0];
      PAR:     txd_s = par_r;
      STOP:    txd_s = 1'b1;
      default: txd_s = 1'b1;
    endcase
  end

  // Registered line and busy outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      txd_r  <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      txd_r  <= txd_s;
      busy_r <= !empty_s || (state_r != IDLE);
    end
  end

  assign iready  = iready_r;
  assign txd_pin = txd_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_axis_rs232_tx.sv
// Bench for axis_rs232_tx: three configurations (8N1/16, 7E2/16, 8O1/4) at 10 cycles/bit.
module tb_axis_rs232_tx;

  localparam int BC = 10;
  localparam int DB [3] = '{8, 7, 8};
  localparam int PM [3] = '{0, 2, 1};
  localparam int SB [3] = '{1, 2, 1};

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic [15:0] frame;
    int         len;
  } vec_t;

  logic       clock;
  logic       rst    [3];
  logic       ivalid [3];
  logic [7:0] idata  [3];
  logic       iready [3];
  logic       txd    [3];
  logic       ctsn   [3];
  logic       busy   [3];

  logic [7:0] exp_mem [3][32];
  int         wr_i [3];
  int         rd_i [3];

  int vectors;
  int miscompares;

  axis_rs232_tx #(.CLOCK_FREQ(1.0e6), .BAUD_RATE(1.0e5), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(16)) dut0 (
    .clock(clock), .reset(rst[0]), .idata(idata[0]), .ivalid(ivalid[0]), .iready(iready[0]),
    .txd_pin(txd[0]), .ctsn_pin(ctsn[0]), .busy(busy[0]));

  axis_rs232_tx #(.CLOCK_FREQ(1.0e6), .BAUD_RATE(1.0e5), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(16)) dut1 (
    .clock(clock), .reset(rst[1]), .idata(idata[1]), .ivalid(ivalid[1]), .iready(iready[1]),
    .txd_pin(txd[1]), .ctsn_pin(ctsn[1]), .busy(busy[1]));

  axis_rs232_tx #(.CLOCK_FREQ(1.0e6), .BAUD_RATE(1.0e5), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .clock(clock), .reset(rst[2]), .idata(idata[2]), .ivalid(ivalid[2]), .iready(iready[2]),
    .txd_pin(txd[2]), .ctsn_pin(ctsn[2]), .busy(busy[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, stop ones.
  function automatic void make_frame(input logic [7:0] b, input int i,
                                     output logic [15:0] bits, output int len);
    int ones;
    bits = 16'h0000;
    len = 1;
    ones = 0;
    for (int k = 0; k < DB[i]; k++) begin
      bits[len] = b[k];
      ones += int'(b[k]);
      len++;
    end
    if (PM[i] != 0) begin
      bits[len] = (PM[i] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      len++;
    end
    for (int s = 0; s < SB[i]; s++) begin
      bits[len] = 1'b1;
      len++;
    end
  endfunction

  // Checks txd and busy on every cycle of one frame starting at the current sample.
  task automatic check_frame(input int i, input logic [15:0] bits, input int len,
                             input string name);
    for (int b = 0; b < len; b++) begin
      for (int c = 0; c < BC; c++) begin
        check($sformatf("%s inst%0d bit%0d cyc%0d {txd,busy}", name, i, b, c),
              {txd[i], busy[i]}, {bits[b], 1'b1});
        step();
      end
    end
  endtask

  task automatic wait_start(input int i, input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      if (txd[i] == 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic push_byte(input int i, input logic [7:0] b);
    for (int g = 0; g < 2000 && !iready[i]; g++) step();
    check($sformatf("iready before push inst%0d", i), iready[i], 1);
    ivalid[i] = 1'b1;
    idata[i] = b;
    step();
    exp_mem[i][wr_i[i]] = b;
    wr_i[i]++;
    ivalid[i] = 1'b0;
  endtask

  task automatic drain_check(input int i, input int n, input string name);
    bit ok;
    logic [15:0] bits;
    int len;
    for (int k = 0; k < n; k++) begin
      wait_start(i, 4000, ok);
      check($sformatf("%s inst%0d start seen", name, i), ok, 1);
      if (!ok) break;
      make_frame(exp_mem[i][rd_i[i]], i, bits, len);
      rd_i[i]++;
      check_frame(i, bits, len, name);
    end
    check($sformatf("%s inst%0d busy after drain", name, i), busy[i], 0);
  endtask

  task automatic random_run(input int i, input int n);
    wr_i[i] = 0;
    rd_i[i] = 0;
    fork
      begin
        for (int k = 0; k < n; k++) begin
          repeat ($urandom_range(0, 12)) step();
          push_byte(i, 8'($urandom));
        end
      end
      drain_check(i, n, "random");
    join
  endtask

  task automatic burst_test();
    logic [7:0] bb [6];
    int acc;
    bit dropped;
    logic rdy;
    for (int k = 0; k < 6; k++) bb[k] = 8'($urandom);
    wr_i[2] = 0;
    rd_i[2] = 0;
    fork
      begin
        acc = 0;
        dropped = 1'b0;
        idata[2] = bb[0];
        ivalid[2] = 1'b1;
        for (int g = 0; g < 3000 && acc < 6; g++) begin
          rdy = iready[2];
          step();
          if (rdy) begin
            exp_mem[2][acc] = idata[2];
            acc++;
            if (acc < 6) idata[2] = bb[acc];
          end
          if (!dropped && !iready[2]) begin
            dropped = 1'b1;
            check("burst accepts before full", acc, 5);
          end
        end
        ivalid[2] = 1'b0;
        check("burst all accepted", acc, 6);
        check("burst iready dropped", dropped, 1);
      end
      begin
        bit ok;
        logic [15:0] bits;
        int len;
        wait_start(2, 50, ok);
        check("burst first start", ok, 1);
        // Frames must follow with no idle cycle between them.
        for (int k = 0; k < 6; k++) begin
          make_frame(exp_mem[2][k], 2, bits, len);
          check_frame(2, bits, len, "burst");
        end
        check("burst busy after last", busy[2], 0);
      end
    join
  endtask

  vec_t tbl [6];

  initial begin
    bit ok;
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      ivalid[i] = 1'b0;
      idata[i] = 8'h00;
      ctsn[i] = 1'b0;
      wr_i[i] = 0;
      rd_i[i] = 0;
    end
    tbl[0] = '{0, 8'hA5, 16'h034A, 10};
    tbl[1] = '{0, 8'hFF, 16'h03FE, 10};
    tbl[2] = '{1, 8'h83, 16'h0606, 11};
    tbl[3] = '{1, 8'h7F, 16'h07FE, 11};
    tbl[4] = '{2, 8'h00, 16'h0600, 11};
    tbl[5] = '{2, 8'h01, 16'h0402, 11};

    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset inst%0d {txd,iready,busy}", i),
            {txd[i], iready[i], busy[i]}, 3'b100);
    end
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    step();
    for (int i = 0; i < 3; i++) check($sformatf("iready after reset inst%0d", i), iready[i], 1);
    repeat (3) step();

    // Directed frames with hand-computed waveforms and start latency.
    for (int v = 0; v < 6; v++) begin
      int i;
      i = tbl[v].inst;
      check($sformatf("vec%0d iready", v), iready[i], 1);
      ivalid[i] = 1'b1;
      idata[i] = tbl[v].data;
      step();
      ivalid[i] = 1'b0;
      step();
      check($sformatf("vec%0d T+1 {txd,busy}", v), {txd[i], busy[i]}, 2'b11);
      step();
      check_frame(i, tbl[v].frame, tbl[v].len, $sformatf("vec%0d", v));
      check($sformatf("vec%0d idle after {txd,busy}", v), {txd[i], busy[i]}, 2'b10);
      repeat (5) step();
    end

    for (int i = 0; i < 3; i++) random_run(i, 8);
    repeat (5) step();

    burst_test();
    repeat (5) step();

`ifdef AXIS_RS232_TX_CTS_EN
    wr_i[0] = 0;
    rd_i[0] = 0;
    ctsn[0] = 1'b1;
    repeat (4) step();
    for (int k = 0; k < 3; k++) push_byte(0, 8'($urandom));
    for (int n = 0; n < 60; n++) begin
      check("cts held off txd", txd[0], 1);
      step();
    end
    ctsn[0] = 1'b0;
    wait_start(0, 5, ok);
    check("cts start latency", ok, 1);
    ctsn[0] = 1'b1;
    begin
      logic [15:0] bits;
      int len;
      make_frame(exp_mem[0][0], 0, bits, len);
      rd_i[0] = 1;
      check_frame(0, bits, len, "cts frame");
    end
    for (int n = 0; n < 80; n++) begin
      check("cts no next frame {txd,busy}", {txd[0], busy[0]}, 2'b11);
      step();
    end
    ctsn[0] = 1'b0;
    drain_check(0, 2, "cts resume");
    repeat (5) step();
`endif

    // Reset in the middle of a data bit with a second byte queued.
    ivalid[0] = 1'b1;
    idata[0] = 8'h3C;
    step();
    idata[0] = 8'hC3;
    step();
    ivalid[0] = 1'b0;
    wait_start(0, 20, ok);
    check("pre-reset start seen", ok, 1);
    repeat (35) step();
    rst[0] = 1'b1;
    step();
    check("mid-frame reset {txd,iready,busy}", {txd[0], iready[0], busy[0]}, 3'b100);
    rst[0] = 1'b0;
    step();
    check("iready after mid-frame reset", iready[0], 1);
    for (int n = 0; n < 300; n++) begin
      check("post-reset quiet {txd,busy}", {txd[0], busy[0]}, 2'b10);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
